// File: rtl/counter_pkg.sv
// counter_pkg: shared mode encodings and one-shot FSM state type
`timescale 1ns/1ps
package counter_pkg;
  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;
  typedef enum logic {ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/counter_next.sv
// counter_next: next-count arithmetic with terminal and wrap detection
//   i_count/i_up/i_mode -> o_next (value after a count step), o_tc (at terminal), o_wrap (step wraps)
`timescale 1ns/1ps
module counter_next
  import counter_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] MOD_MAX = '1
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_up,
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_next,
  output logic             o_tc,
  output logic             o_wrap
);
  logic w_wrap_mode;
  assign w_wrap_mode = (i_mode == MODE_WRAP) || (i_mode == MODE_RSVD);
  // Terminal check gates the +1/-1 so MOD_MAX+1 and 0-1 are never selected
  always_comb begin
    o_tc   = i_up ? (i_count == MOD_MAX) : (i_count == {WIDTH{1'b0}});
    o_wrap = o_tc && w_wrap_mode;
    o_next = !o_tc ? (i_up ? i_count + 1'b1 : i_count - 1'b1)
           : w_wrap_mode ? (i_up ? {WIDTH{1'b0}} : MOD_MAX)
           : i_count;
  end
endmodule

// File: rtl/multimode_counter.sv
// multimode_counter: modulo up/down counter with clamped load and wrap/saturate/one-shot modes
//   i_clk, i_reset_n (async, active-low), i_clear (sync), i_ld_enable_n + i_load (clamped load),
//   i_cnt_enable_n, i_up, i_mode -> o_count, o_tc (comb terminal), o_wrap (1-cycle pulse), o_done
`timescale 1ns/1ps
module multimode_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] MOD_MAX = '1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_cnt_enable_n,
  input  logic             i_ld_enable_n,
  input  logic [WIDTH-1:0] i_load,
  input  logic             i_clear,
  input  logic             i_up,
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_wrap,
  output logic             o_done
);
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_done;
  state_t           r_state;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load;
  logic             w_tc;
  logic             w_wrap;

  counter_next #(.WIDTH(WIDTH), .MOD_MAX(MOD_MAX)) u_next (
    .i_count (r_count),
    .i_up    (i_up),
    .i_mode  (i_mode),
    .o_next  (w_next),
    .o_tc    (w_tc),
    .o_wrap  (w_wrap)
  );

  assign w_load  = (i_load > MOD_MAX) ? MOD_MAX : i_load;
  assign o_count = r_count;
  assign o_tc    = w_tc;
  assign o_wrap  = r_wrap;
  assign o_done  = r_done;

  // Leaving ST_DONE on a mode change only rearms the FSM; the count step waits for the next edge
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
      r_state <= ST_RUN;
    end else if (i_clear) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
      r_state <= ST_RUN;
    end else if (!i_ld_enable_n) begin
      r_count <= w_load;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
      r_state <= ST_RUN;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        ST_DONE: begin
          if (i_mode != MODE_ONESHOT) begin
            r_state <= ST_RUN;
            r_done  <= 1'b0;
          end
        end
        default: begin
          if (!i_cnt_enable_n) begin
            r_count <= w_next;
            r_wrap  <= w_wrap;
            if (w_tc && i_mode == MODE_ONESHOT) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multimode_counter.sv
// tb_multimode_counter: directed table-driven check of multimode_counter (WIDTH=4, MOD_MAX=9)
`timescale 1ns/1ps
module tb_multimode_counter;
  import counter_pkg::*;
  localparam int W = 4;
  localparam int N = 30;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cnt_n = 1'b1;
  logic         ld_n = 1'b1;
  logic         clr = 1'b0;
  logic         up = 1'b1;
  logic [1:0]   mode = MODE_WRAP;
  logic [W-1:0] load = '0;
  logic [W-1:0] count;
  logic         tc, wrap, done;
  int           errs = 0;
  int           checks = 0;

  typedef struct {
    logic         clr, ld_n, cnt_n, up;
    logic [1:0]   mode;
    logic [W-1:0] load;
    logic [W-1:0] e_count;
    logic         e_tc, e_wrap, e_done;
  } vec_t;
  vec_t tbl [N];

  multimode_counter #(.WIDTH(W), .MOD_MAX(4'd9)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_cnt_enable_n (cnt_n),
    .i_ld_enable_n  (ld_n),
    .i_load         (load),
    .i_clear        (clr),
    .i_up           (up),
    .i_mode         (mode),
    .o_count        (count),
    .o_tc           (tc),
    .o_wrap         (wrap),
    .o_done         (done)
  );

  always #1 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] ec, input logic et, ew, ed);
    checks++;
    if ({count, tc, wrap, done} !== {ec, et, ew, ed}) begin
      errs++;
      $display("FAIL %s: got count=%0d tc=%b wrap=%b done=%b, want count=%0d tc=%b wrap=%b done=%b",
               name, count, tc, wrap, done, ec, et, ew, ed);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //           clr ld_n cnt_n up  mode          load   cnt  tc   wrap done
    tbl = '{
      '{1'b0, 1'b0, 1'b1, 1'b1, MODE_WRAP,    4'd3,  4'd3, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b1, MODE_WRAP,    4'd12, 4'd9, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b0, MODE_SAT,     4'd2,  4'd2, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0, MODE_SAT,     4'd0,  4'd1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0, MODE_SAT,     4'd0,  4'd0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0, MODE_SAT,     4'd0,  4'd0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0, MODE_SAT,     4'd0,  4'd0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b1, MODE_ONESHOT, 4'd7,  4'd7, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, MODE_ONESHOT, 4'd0,  4'd8, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, MODE_ONESHOT, 4'd0,  4'd9, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, MODE_ONESHOT, 4'd0,  4'd9, 1'b1, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b1, MODE_ONESHOT, 4'd0,  4'd9, 1'b1, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b1, MODE_ONESHOT, 4'd0,  4'd9, 1'b1, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b1, MODE_ONESHOT, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, MODE_ONESHOT, 4'd0,  4'd1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b1, MODE_WRAP,    4'd5,  4'd0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, MODE_WRAP,    4'd5,  4'd5, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b0, MODE_WRAP,    4'd0,  4'd0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0, MODE_WRAP,    4'd0,  4'd9, 1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0, MODE_WRAP,    4'd0,  4'd8, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b1, MODE_RSVD,    4'd9,  4'd9, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, MODE_RSVD,    4'd0,  4'd0, 1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b1, MODE_ONESHOT, 4'd8,  4'd8, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, MODE_ONESHOT, 4'd0,  4'd9, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, MODE_ONESHOT, 4'd0,  4'd9, 1'b1, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b1, MODE_WRAP,    4'd0,  4'd9, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, MODE_WRAP,    4'd0,  4'd0, 1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0, MODE_WRAP,    4'd0,  4'd9, 1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, MODE_WRAP,    4'd0,  4'd9, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b1, MODE_WRAP,    4'd0,  4'd0, 1'b0, 1'b0, 1'b0}
    };

    #3;
    chk("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    cnt_n = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      logic [W-1:0] e;
      tick();
      e = W'(i % 10);
      chk($sformatf("upwrap%0d", i), e, e == 4'd9, e == 4'd0, 1'b0);
    end

    for (int i = 0; i < N; i++) begin
      clr   = tbl[i].clr;
      ld_n  = tbl[i].ld_n;
      cnt_n = tbl[i].cnt_n;
      up    = tbl[i].up;
      mode  = tbl[i].mode;
      load  = tbl[i].load;
      tick();
      chk($sformatf("vec%0d", i), tbl[i].e_count, tbl[i].e_tc, tbl[i].e_wrap, tbl[i].e_done);
    end

    clr = 1'b0; up = 1'b1; mode = MODE_WRAP; cnt_n = 1'b1;
    ld_n = 1'b0; load = 4'd6;
    tick();
    chk("ld6", 4'd6, 1'b0, 1'b0, 1'b0);
    ld_n = 1'b1;
    @(posedge clk);
    #0.5 rst_n = 1'b0;
    #0.2 chk("async_rst6", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    mode = MODE_ONESHOT; ld_n = 1'b0; load = 4'd9;
    tick();
    ld_n = 1'b1; cnt_n = 1'b0;
    tick();
    chk("done9", 4'd9, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #0.5 rst_n = 1'b0;
    #0.2 chk("async_rst_done", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mode = MODE_WRAP;
    tick();
    chk("resume1", 4'd1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("resume2", 4'd2, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
